// File: rtl/frame_buf_arbiter.sv
// SDRAM burst scheduler between the camera write path and the VGA read path.
// Double-buffers frames so the display always reads the last complete camera frame.
module frame_buf_arbiter #(
    parameter int FRAME_WORDS = 1296000,
    parameter int OFS_W       = 21,
    parameter int BURST_LEN   = 256,
    parameter int RD_LOW      = 512,
    parameter int LVL_W       = 11
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             VSYNC_Sig,
    input  logic             cam_frame_start,
    input  logic [LVL_W-1:0] wr_fifo_level,
    input  logic [LVL_W-1:0] rd_fifo_level,
    output logic             cmd_req,
    output logic             cmd_we,
    output logic [OFS_W:0]   cmd_addr,
    output logic [8:0]       cmd_len,
    input  logic             cmd_ack,
    input  logic             burst_done,
    output logic             rd_bank,
    output logic             wr_bank
);

    // state   | meaning
    // IDLE    | apply pending frame events, else pick next burst
    // RD_REQ  | read burst requested, waiting for cmd_ack
    // RD_WAIT | read burst in flight, waiting for burst_done
    // WR_REQ  | write burst requested, waiting for cmd_ack
    // WR_WAIT | write burst in flight, waiting for burst_done
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    localparam logic [OFS_W-1:0] FW  = OFS_W'(FRAME_WORDS);
    localparam logic [OFS_W-1:0] BL  = OFS_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] RDL = LVL_W'(RD_LOW);

    state_t           state_q, state_d;
    logic [OFS_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic             rd_bank_q, rd_bank_d, wr_bank_q, wr_bank_d;
    logic             last_done_q, last_done_d;
    logic             pend_vs_q, pend_vs_d, pend_cs_q, pend_cs_d;
    logic             vs_q;
    logic             cmd_req_q, cmd_req_d, cmd_we_q, cmd_we_d;
    logic [OFS_W:0]   cmd_addr_q, cmd_addr_d;
    logic [8:0]       cmd_len_q, cmd_len_d;

    logic             vs_fall, rd_need, wr_need;
    logic [OFS_W-1:0] rem_r, rem_w;
    logic [8:0]       len_r, len_w;

    assign vs_fall = vs_q & ~VSYNC_Sig;
    assign rem_r   = FW - rd_ptr_q;
    assign rem_w   = FW - wr_ptr_q;
    assign len_r   = (rem_r < BL) ? 9'(rem_r) : 9'(BURST_LEN);
    assign len_w   = (rem_w < BL) ? 9'(rem_w) : 9'(BURST_LEN);
    assign rd_need = (rd_fifo_level < RDL) && (rd_ptr_q < FW);
    assign wr_need = (wr_ptr_q < FW) && (32'(wr_fifo_level) >= 32'(len_w));

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_bank_d   = rd_bank_q;
        wr_bank_d   = wr_bank_q;
        last_done_d = last_done_q;
        pend_vs_d   = pend_vs_q | vs_fall;
        pend_cs_d   = pend_cs_q | cam_frame_start;
        cmd_req_d   = cmd_req_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        case (state_q)
            IDLE: begin
                if (pend_cs_q || pend_vs_q) begin
                    if (pend_cs_q) begin
                        // Only a fully written frame becomes eligible for display.
                        if (wr_ptr_q == FW) begin
                            last_done_d = wr_bank_q;
                            wr_bank_d   = ~wr_bank_q;
                        end
                        wr_ptr_d  = '0;
                        pend_cs_d = cam_frame_start;
                    end
                    if (pend_vs_q) begin
                        rd_bank_d = last_done_d;
                        rd_ptr_d  = '0;
                        pend_vs_d = vs_fall;
                    end
                end else if (rd_need) begin
                    state_d    = RD_REQ;
                    cmd_req_d  = 1'b1;
                    cmd_we_d   = 1'b0;
                    cmd_addr_d = {rd_bank_q, rd_ptr_q};
                    cmd_len_d  = len_r;
                end else if (wr_need) begin
                    state_d    = WR_REQ;
                    cmd_req_d  = 1'b1;
                    cmd_we_d   = 1'b1;
                    cmd_addr_d = {wr_bank_q, wr_ptr_q};
                    cmd_len_d  = len_w;
                end
            end
            RD_REQ: begin
                if (cmd_ack) begin
                    cmd_req_d = 1'b0;
                    rd_ptr_d  = rd_ptr_q + OFS_W'(cmd_len_q);
                    state_d   = RD_WAIT;
                end
            end
            WR_REQ: begin
                if (cmd_ack) begin
                    cmd_req_d = 1'b0;
                    wr_ptr_d  = wr_ptr_q + OFS_W'(cmd_len_q);
                    state_d   = WR_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (burst_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_bank_q   <= 1'b0;
            wr_bank_q   <= 1'b1;
            last_done_q <= 1'b0;
            pend_vs_q   <= 1'b0;
            pend_cs_q   <= 1'b0;
            vs_q        <= 1'b1;
            cmd_req_q   <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_bank_q   <= rd_bank_d;
            wr_bank_q   <= wr_bank_d;
            last_done_q <= last_done_d;
            pend_vs_q   <= pend_vs_d;
            pend_cs_q   <= pend_cs_d;
            vs_q        <= VSYNC_Sig;
            cmd_req_q   <= cmd_req_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
        end
    end

    assign cmd_req  = cmd_req_q;
    assign cmd_we   = cmd_we_q;
    assign cmd_addr = cmd_addr_q;
    assign cmd_len  = cmd_len_q;
    assign rd_bank  = rd_bank_q;
    assign wr_bank  = wr_bank_q;

endmodule
